// File: rtl/load_align_unit_if.sv
// Load/align unit bus bundle: datapath request/response side plus the
// wait-state data memory read port.
interface load_align_unit_if #(
   parameter int W  = 32,
   parameter int AW = 32
);
   logic          REQ;
   logic [AW-1:0] ADDR;
   logic [1:0]    CT;
   logic          SX;
   logic          BUSY;
   logic          DONE;
   logic          EXC;
   logic [W-1:0]  OUT;
   logic          MEM_RD;
   logic [AW-1:0] MEM_ADDR;
   logic [W-1:0]  MEM_DATA;
   logic          MEM_ACK;

   // slave: the load/align unit itself
   modport slave (
      input  REQ, ADDR, CT, SX, MEM_DATA, MEM_ACK,
      output BUSY, DONE, EXC, OUT, MEM_RD, MEM_ADDR
   );

   // master: datapath + memory model driving the unit
   modport master (
      output REQ, ADDR, CT, SX, MEM_DATA, MEM_ACK,
      input  BUSY, DONE, EXC, OUT, MEM_RD, MEM_ADDR
   );
endinterface

// File: rtl/load_align_unit.sv
// Sequential load/align unit: fetches one or two words over a wait-state
// handshake, extracts the addressed bytes and zero/sign-extends them.

// One output byte lane: picks byte off+LANE of the two-word window, or the
// extension fill when the lane lies above the access size.
module load_align_lane #(
   parameter int NB   = 4,
   parameter int OB   = 2,
   parameter int LANE = 0
) (
   input  logic [2*NB-1:0][7:0] cat,
   input  logic [OB:0]          off,
   input  logic [OB:0]          sz,
   input  logic                 fill,
   output logic [7:0]           lane_byte
);
   localparam logic [OB:0] LN = (OB+1)'(LANE);

   logic [OB:0] idx;

   assign idx       = off + LN;
   assign lane_byte = (LN < sz) ? cat[idx] : {8{fill}};
endmodule

module load_align_unit #(
   parameter int W                = 32,
   parameter int AW               = 32,
   parameter int ALLOW_MISALIGNED = 0
) (
   input logic            clk,
   input logic            reset_n,
   load_align_unit_if.slave bus
);
   localparam int NB = W / 8;
   localparam int OB = $clog2(NB);
   localparam logic [OB:0] NBV = (OB+1)'(NB);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RD0  = 2'd1;
   localparam logic [1:0] RD1  = 2'd2;

   logic [1:0]    state;
   logic [AW-1:0] base;
   logic [OB:0]   off;
   logic [OB:0]   sz;
   logic          sx_q;
   logic          last_q;
   logic [W-1:0]  word0;
   logic [W-1:0]  out_q;
   logic          done_q;
   logic          exc_q;

   // request classification, only meaningful while IDLE
   logic [OB:0]   sz_in;
   logic [OB-1:0] o_in;
   logic [OB-1:0] amask;
   logic          ill;
   logic          mis;
   logic          fits;

   always_comb begin
      sz_in = NBV;
      case (bus.CT)
         2'd1:    sz_in = (OB+1)'(2);
         2'd2:    sz_in = (OB+1)'(1);
         default: sz_in = NBV;
      endcase
   end

   assign o_in  = bus.ADDR[OB-1:0];
   // size-1 as a low-bit mask; the word case wraps to all ones
   assign amask = sz_in[OB-1:0] - OB'(1);
   assign ill   = (bus.CT == 2'd3);
   assign mis   = |(o_in & amask);
   assign fits  = ({1'b0, o_in} + sz_in) <= NBV;

   // extraction window: second word only exists while finishing RD1
   logic [2*NB-1:0][7:0] cat;
   logic [NB-1:0][7:0]   ext;
   logic [OB:0]          sidx;
   logic                 fill;

   assign cat  = (state == RD1) ? {bus.MEM_DATA, word0} : {{W{1'b0}}, bus.MEM_DATA};
   assign sidx = off + sz - (OB+1)'(1);
   assign fill = sx_q && (sz != NBV) && cat[sidx][7];

   for (genvar i = 0; i < NB; i++) begin : g_lane
      load_align_lane #(.NB(NB), .OB(OB), .LANE(i)) u_lane (
         .cat       (cat),
         .off       (off),
         .sz        (sz),
         .fill      (fill),
         .lane_byte (ext[i])
      );
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state  <= IDLE;
         base   <= '0;
         off    <= '0;
         sz     <= '0;
         sx_q   <= 1'b0;
         last_q <= 1'b0;
         word0  <= '0;
         out_q  <= '0;
         done_q <= 1'b0;
         exc_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         exc_q  <= 1'b0;
         case (state)
            IDLE: if (bus.REQ) begin
               base   <= {bus.ADDR[AW-1:OB], {OB{1'b0}}};
               off    <= {1'b0, o_in};
               sz     <= sz_in;
               sx_q   <= bus.SX;
               last_q <= fits;
               if (ill || (mis && (ALLOW_MISALIGNED == 0))) begin
                  done_q <= 1'b1;
                  exc_q  <= 1'b1;
                  out_q  <= '0;
               end else begin
                  state <= RD0;
               end
            end
            RD0: if (bus.MEM_ACK) begin
               word0 <= bus.MEM_DATA;
               if (last_q) begin
                  state  <= IDLE;
                  done_q <= 1'b1;
                  out_q  <= ext;
               end else begin
                  state <= RD1;
               end
            end
            RD1: if (bus.MEM_ACK) begin
               state  <= IDLE;
               done_q <= 1'b1;
               out_q  <= ext;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.BUSY     = (state != IDLE);
   assign bus.MEM_RD   = (state != IDLE);
   assign bus.MEM_ADDR = (state == RD0) ? base :
                         (state == RD1) ? base + AW'(NB) : '0;
   assign bus.DONE     = done_q;
   assign bus.EXC      = exc_q;
   assign bus.OUT      = out_q;
endmodule
